coherence_bus_ctrl: RTL

//  Memory-side responder for two snooping data caches and two icaches. Arbitrates per-core

---
 rtl/coherence_bus_ctrl_if.sv | 57 +++++
 rtl/coherence_bus_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_ctrl_if.sv
// coherence_bus_ctrl_if
//   Bundles every signal between the coherence controller, the two cores'
//   caches and the single-port RAM model.
//   Modports:
//     slave  - the controller: takes cache requests and RAM status,
//              drives waits, fill data, snoop controls and RAM strobes.
//     master - the caches and RAM model: the mirror image of slave.
//   Signals (per-core arrays are indexed by core number):
//     iREN/iaddr -> iwait/iload        instruction word fetch
//     dREN/dWEN/daddr/dstore -> dwait/dload   data block fill / writeback
//     cctrans/ccwrite -> ccwait/ccinv/ccsnoopaddr   snoop handshake
//     ramREN/ramWEN/ramaddr/ramstore <- ramload/ramstate   RAM port
interface coherence_bus_ctrl_if #(
  parameter int CPUS = 2,
  parameter int AW   = 32
);
  // Cache-side requests
  logic [CPUS-1:0]         iREN;
  logic [CPUS-1:0][AW-1:0] iaddr;
  logic [CPUS-1:0]         dREN;
  logic [CPUS-1:0]         dWEN;
  logic [CPUS-1:0][AW-1:0] daddr;
  logic [CPUS-1:0][AW-1:0] dstore;
  logic [CPUS-1:0]         cctrans;
  logic [CPUS-1:0]         ccwrite;

  // Cache-side responses
  logic [CPUS-1:0]         iwait;
  logic [CPUS-1:0][AW-1:0] iload;
  logic [CPUS-1:0]         dwait;
  logic [CPUS-1:0][AW-1:0] dload;
  logic [CPUS-1:0]         ccwait;
  logic [CPUS-1:0]         ccinv;
  logic [CPUS-1:0][AW-1:0] ccsnoopaddr;

  // RAM port
  logic                    ramREN;
  logic                    ramWEN;
  logic [AW-1:0]           ramaddr;
  logic [AW-1:0]           ramstore;
  logic [AW-1:0]           ramload;
  logic [1:0]              ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite,
    input  ramload, ramstate,
    output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite,
    output ramload, ramstate,
    input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
    input  ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl
//   Memory-side responder for two snooping data caches and two instruction
//   caches sharing one single-port RAM. One transaction at a time:
//     WB     - two-word writeback from a data cache to RAM
//     SNOOP  - probe the other data cache, then fill the requester either
//              from RAM (RD0/RD1) or cache-to-cache (C2C0/C2C1), in which case
//              the supplied block is also written through to RAM
//     IFETCH - single instruction word from RAM
//   Ports:
//     CLK   - system clock, all state on the rising edge
//     nRST  - asynchronous active-low reset
//     bus   - coherence_bus_ctrl_if.slave (caches + RAM)
//   The state, granted core and round-robin pointer are registered; the bus
//   outputs are decoded from that state together with the live RAM status,
//   because a word completes in the same cycle ramstate reports ACCESS.
module coherence_bus_ctrl (
  input logic                 CLK,
  input logic                 nRST,
  coherence_bus_ctrl_if.slave bus
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [3:0] {
    IDLE,
    WB,
    SNOOP,
    RESP,
    RD0,
    RD1,
    C2C0,
    C2C1,
    IFETCH
  } state_t;

  state_t state;
  logic   req;    // granted core
  logic   rr;     // core that last completed a data block
  logic   wcnt;   // writeback word counter

  logic   snp;    // snooper is always the other core
  logic   access; // RAM word completes this cycle

  assign snp    = ~req;
  assign access = (bus.ramstate == RAM_ACCESS);

  // Pick one core from a non-empty request vector; on a tie the core that did
  // not finish the last data block wins.
  function automatic logic pick(input logic [1:0] v, input logic last);
    if (v == 2'b11) return ~last;
    return v[1];
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      req   <= 1'b0;
      rr    <= 1'b0;
      wcnt  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wcnt <= 1'b0;
          if (|bus.dWEN) begin
            req   <= pick(bus.dWEN, rr);
            state <= WB;
          end else if (|bus.dREN) begin
            req   <= pick(bus.dREN, rr);
            state <= SNOOP;
          end else if (|bus.iREN) begin
            req   <= pick(bus.iREN, rr);
            state <= IFETCH;
          end
        end

        WB: begin
          if (access) begin
            if (wcnt) begin
              wcnt  <= 1'b0;
              rr    <= req;
              state <= IDLE;
            end else begin
              wcnt  <= 1'b1;
            end
          end
        end

        // The snooper gets one full cycle to look up its tags before its
        // answer is sampled in RESP.
        SNOOP: state <= RESP;

        RESP: state <= bus.cctrans[snp] ? C2C0 : RD0;

        RD0: if (access) state <= RD1;

        RD1: begin
          if (access) begin
            rr    <= req;
            state <= IDLE;
          end
        end

        C2C0: if (access) state <= C2C1;

        C2C1: begin
          if (access) begin
            rr    <= req;
            state <= IDLE;
          end
        end

        IFETCH: if (access) state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets its idle value first, so no path through the case
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    bus.iwait       = 2'b11;
    bus.dwait       = 2'b11;
    bus.iload       = '0;
    bus.dload       = '0;
    bus.ccwait      = 2'b00;
    bus.ccinv       = 2'b00;
    bus.ccsnoopaddr = '0;
    bus.ramREN      = 1'b0;
    bus.ramWEN      = 1'b0;
    bus.ramaddr     = '0;
    bus.ramstore    = '0;

    case (state)
      WB: begin
        bus.ramWEN     = 1'b1;
        bus.ramaddr    = bus.daddr[req];
        bus.ramstore   = bus.dstore[req];
        bus.dwait[req] = ~access;
      end

      SNOOP, RESP: begin
        bus.ccwait[snp]      = 1'b1;
        bus.ccsnoopaddr[snp] = bus.daddr[req];
        bus.ccinv[snp]       = bus.ccwrite[req];
      end

      RD0, RD1: begin
        bus.ccwait[snp] = 1'b1;
        bus.ramREN      = 1'b1;
        bus.ramaddr     = bus.daddr[req];
        bus.dload[req]  = bus.ramload;
        bus.dwait[req]  = ~access;
      end

      // The snooper's block goes to the requester and to RAM in the same
      // cycle, so both caches advance together on each RAM ACCESS.
      C2C0, C2C1: begin
        bus.ccwait[snp] = 1'b1;
        bus.dload[req]  = bus.dstore[snp];
        bus.ramWEN      = 1'b1;
        bus.ramaddr     = bus.daddr[req];
        bus.ramstore    = bus.dstore[snp];
        bus.dwait[req]  = ~access;
        bus.dwait[snp]  = ~access;
      end

      IFETCH: begin
        bus.ramREN     = 1'b1;
        bus.ramaddr    = bus.iaddr[req];
        bus.iload[req] = bus.ramload;
        bus.iwait[req] = ~access;
      end

      default: ;
    endcase
  end

endmodule
